// File: rtl/cpu_host_loader.sv
// Host-side command engine for the CPU's external imem/dmem ports and run enable.
// Executes one write/read/run command at a time and returns one response per command.
module cpu_host_loader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  input  logic        run_abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic [63:0] rsp_rdata,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        enable
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RUN, RSP} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t           state;
  logic             is_dmem;
  logic [2:0]       wcnt;
  logic [CNT_W-1:0] run_cnt, run_tgt, run_nxt, req_cnt;
  logic             op_illegal, misaligned;

  assign run_nxt = run_cnt + CNT_W'(1);
  assign req_cnt = cmd_wdata[CNT_W-1:0];

  // ops 0/2 target imem (word aligned), 1/3 target dmem (dword aligned)
  always_comb begin
    op_illegal = (cmd_op > 3'd4);
    misaligned = 1'b0;
    if (cmd_op == 3'd0 || cmd_op == 3'd2) misaligned = (cmd_addr[1:0] != 2'b00);
    if (cmd_op == 3'd1 || cmd_op == 3'd3) misaligned = (cmd_addr[2:0] != 3'b000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      enable      <= 1'b0;
      is_dmem     <= 1'b0;
      wcnt        <= '0;
      run_cnt     <= '0;
      run_tgt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (op_illegal || misaligned) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              case (cmd_op)
                3'd0: begin
                  addr_ext  <= cmd_addr;
                  wdata_ext <= cmd_wdata[31:0];
                  wen_ext   <= 1'b1;
                  state     <= WRITE;
                end
                3'd1: begin
                  addr_ext_2  <= cmd_addr;
                  wdata_ext_2 <= cmd_wdata;
                  wen_ext_2   <= 1'b1;
                  state       <= WRITE;
                end
                3'd2: begin
                  addr_ext <= cmd_addr;
                  ren_ext  <= 1'b1;
                  is_dmem  <= 1'b0;
                  state    <= RD_REQ;
                end
                3'd3: begin
                  addr_ext_2 <= cmd_addr;
                  ren_ext_2  <= 1'b1;
                  is_dmem    <= 1'b1;
                  state      <= RD_REQ;
                end
                default: begin
                  run_tgt <= req_cnt;
                  run_cnt <= '0;
                  if (req_cnt == '0) begin
                    state     <= RSP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                  end else begin
                    enable <= 1'b1;
                    state  <= RUN;
                  end
                end
              endcase
            end
          end
        end
        WRITE: begin
          wen_ext   <= 1'b0;
          wen_ext_2 <= 1'b0;
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RD_REQ: begin
          ren_ext   <= 1'b0;
          ren_ext_2 <= 1'b0;
          wcnt      <= 3'd1;
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wcnt == LAT) begin
            rsp_rdata <= is_dmem ? rdata_ext_2 : {32'b0, rdata_ext};
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        RUN: begin
          // run_nxt counts the cycle ending at this edge, which had enable high
          run_cnt <= run_nxt;
          if (run_nxt == run_tgt || run_abort) begin
            enable    <= 1'b0;
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= 64'(run_nxt);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_host_loader.sv
// Directed bench for cpu_host_loader with simple imem/dmem models (read latency 1).
module tb_cpu_host_loader;
  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready, run_abort = 0;
  logic [2:0]  cmd_op = 0;
  logic [63:0] cmd_addr = 0, cmd_wdata = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_err;
  logic [63:0] rsp_rdata;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable;
  logic [31:0] wdata_ext, rdata_ext = 0;
  logic [63:0] rdata_ext_2 = 0;

  cpu_host_loader #(.RD_LAT(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .run_abort(run_abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .rdata_ext(rdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .enable(enable)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [63:0] dmem [64];
  initial for (int i = 0; i < 64; i++) begin imem[i] = 0; dmem[i] = 0; end

  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext[7:2]]   <= wdata_ext;
    if (ren_ext)   rdata_ext             <= imem[addr_ext[7:2]];
    if (wen_ext_2) dmem[addr_ext_2[7:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2           <= dmem[addr_ext_2[7:3]];
  end

  // running totals; tests take deltas around each command
  int n_wen, n_ren, n_wen2, n_ren2, n_en, n_rdylo, n_rsp, n_overlap;
  logic [63:0] cap_addr;
  logic [31:0] cap_wdata;
  initial begin
    n_wen = 0; n_ren = 0; n_wen2 = 0; n_ren2 = 0; n_en = 0; n_rdylo = 0; n_rsp = 0; n_overlap = 0;
    cap_addr = 0; cap_wdata = 0;
    forever begin
      @(negedge clk);
      if (wen_ext) begin n_wen++; cap_addr = addr_ext; cap_wdata = wdata_ext; end
      if (ren_ext)   n_ren++;
      if (wen_ext_2) n_wen2++;
      if (ren_ext_2) n_ren2++;
      if (enable)    n_en++;
      if (!cmd_ready) n_rdylo++;
      if (rsp_valid) n_rsp++;
      if (enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) n_overlap++;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic        r_err;
  logic [63:0] r_data;
  int d_wen, d_ren, d_wen2, d_ren2, d_en, d_rdylo;

  task automatic do_cmd(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
    int n, b_wen, b_ren, b_wen2, b_ren2, b_en, b_rdylo;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", {63'b0, cmd_ready}, 64'd1);
    b_wen = n_wen; b_ren = n_ren; b_wen2 = n_wen2; b_ren2 = n_ren2; b_en = n_en; b_rdylo = n_rdylo;
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    if (!rsp_valid) chk("rsp_timeout", {63'b0, rsp_valid}, 64'd1);
    r_err = rsp_err; r_data = rsp_rdata;
    @(posedge clk);
    #1;
    d_wen = n_wen - b_wen; d_ren = n_ren - b_ren; d_wen2 = n_wen2 - b_wen2;
    d_ren2 = n_ren2 - b_ren2; d_en = n_en - b_en; d_rdylo = n_rdylo - b_rdylo;
  endtask

  initial begin
    int k, rsp0;
    logic stable;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {56'b0, cmd_ready, rsp_valid, rsp_err, enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'd0);
    chk("reset_rdata_addr", rsp_rdata | addr_ext | addr_ext_2, 64'd0);
    rst = 0;

    do_cmd(3'd0, 64'h8, 64'h0050_0093);
    chk("wr_imem_err", {63'b0, r_err}, 64'd0);
    chk("wr_imem_rdata", r_data, 64'd0);
    chk("wr_imem_wen_cycles", 64'(d_wen), 64'd1);
    chk("wr_imem_addr", cap_addr, 64'h8);
    chk("wr_imem_wdata", {32'b0, cap_wdata}, 64'h0050_0093);
    chk("wr_throughput_busy", 64'(d_rdylo), 64'd2);

    do_cmd(3'd1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    chk("wr_dmem_err", {63'b0, r_err}, 64'd0);
    chk("wr_dmem_wen2", 64'(d_wen2), 64'd1);
    do_cmd(3'd3, 64'h10, 64'h0);
    chk("rd_dmem_data", r_data, 64'hDEAD_BEEF_CAFE_F00D);
    chk("rd_dmem_ren2", 64'(d_ren2), 64'd1);

    do_cmd(3'd0, 64'h20, 64'h1234_5678_FFFF_FFFF);
    do_cmd(3'd2, 64'h20, 64'h0);
    chk("rd_imem_zext", r_data, 64'h0000_0000_FFFF_FFFF);
    chk("rd_imem_ren", 64'(d_ren), 64'd1);

    do_cmd(3'd3, 64'h14, 64'h0);
    chk("rd_dmem_unal_err", {63'b0, r_err}, 64'd1);
    chk("rd_dmem_unal_noren", 64'(d_ren2), 64'd0);
    chk("rd_dmem_unal_rdata", r_data, 64'd0);
    do_cmd(3'd0, 64'h2, 64'h55);
    chk("wr_imem_unal_err", {63'b0, r_err}, 64'd1);
    chk("wr_imem_unal_nowen", 64'(d_wen), 64'd0);
    do_cmd(3'd6, 64'h0, 64'h0);
    chk("illegal_op_err", {63'b0, r_err}, 64'd1);

    do_cmd(3'd4, 64'h0, 64'd5);
    chk("run5_rdata", r_data, 64'd5);
    chk("run5_en_cycles", 64'(d_en), 64'd5);
    chk("run5_err", {63'b0, r_err}, 64'd0);
    do_cmd(3'd4, 64'h0, 64'd0);
    chk("run0_rdata", r_data, 64'd0);
    chk("run0_en_cycles", 64'(d_en), 64'd0);

    k = 0;
    fork
      do_cmd(3'd4, 64'h0, 64'd100);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (enable) k++;
          if (k == 10) begin
            run_abort = 1;
            @(negedge clk);
            run_abort = 0;
            break;
          end
        end
      end
    join
    chk("run_abort_rdata", r_data, 64'd10);
    chk("run_abort_en_cycles", 64'(d_en), 64'd10);

    rsp_ready = 0;
    do_cmd(3'd3, 64'h10, 64'h0);
    stable = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== 64'hDEAD_BEEF_CAFE_F00D || rsp_err || cmd_ready) stable = 0;
    end
    chk("hold_stable", {63'b0, stable}, 64'd1);
    rsp_ready = 1;
    @(posedge clk);
    chk("hold_first_rdata", r_data, 64'hDEAD_BEEF_CAFE_F00D);

    chk("no_mem_access_while_run", 64'(n_overlap), 64'd0);

    // reset in the middle of a long run
    @(negedge clk);
    cmd_valid = 1; cmd_op = 3'd4; cmd_addr = 0; cmd_wdata = 64'd50;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("run_before_rst_en", {63'b0, enable}, 64'd1);
    rsp0 = n_rsp;
    rst = 1;
    @(negedge clk);
    chk("rst_mid_run_outs", {61'b0, enable, rsp_valid, cmd_ready}, 64'd0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_run_ready", {63'b0, cmd_ready}, 64'd1);
    chk("rst_mid_run_no_rsp", 64'(n_rsp - rsp0), 64'd0);

    do_cmd(3'd3, 64'h10, 64'h0);
    chk("post_rst_rd_dmem", r_data, 64'hDEAD_BEEF_CAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_host_loader.md
Name: cpu_host_loader

Overview:
- Host-side initiator for the processor's external memory-access ports: instruction memory (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext) and data memory (the *_ext_2 set).
- Accepts commands from a host over a valid/ready channel: write or read a memory word, or run the CPU for N cycles by driving its enable input.
- Returns one response per command.
- Sits between the testbench/host link and the cpu top level, and owns the cpu enable.

Parameters:
- RD_LAT, 1: cycles from the ren_ext/ren_ext_2 cycle to valid rdata_ext/rdata_ext_2 (range 1..4).
- CNT_W, 32: width of the run cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  0=WR_IMEM 1=WR_DMEM 2=RD_IMEM 3=RD_DMEM 4=RUN, 5-7 illegal
- cmd_addr  in  64  byte address
- cmd_wdata  in  64  write data; for RUN, bits [CNT_W-1:0] are the cycle count
- run_abort  in  1  terminates RUN early
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_err  out  1  command rejected
- rsp_rdata  out  64  read data or cycles executed
- addr_ext  out  64  imem address
- wen_ext  out  1  imem write enable
- ren_ext  out  1  imem read enable
- wdata_ext  out  32  imem write data
- rdata_ext  in  32  imem read data
- addr_ext_2  out  64  dmem address
- wen_ext_2  out  1  dmem write enable
- ren_ext_2  out  1  dmem read enable
- wdata_ext_2  out  64  dmem write data
- rdata_ext_2  in  64  dmem read data
- enable  out  1  cpu run enable

Behaviour:
- All outputs are registered.
- On any clk edge with rst=1: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all addr/wdata=0, all wen/ren=0, enable=0, counter=0.
  - rst mid-operation aborts immediately. An in-flight write pulse or enable drops on that edge. No response is produced.
- States: IDLE, WRITE, RD_REQ, RD_WAIT, RUN, RSP.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid and cmd_ready are both high; command fields are latched on that edge.
- Checks at accept:
  - Illegal op (5-7): go to RSP with rsp_err=1, rsp_rdata=0.
  - IMEM op with cmd_addr[1:0]!=0: go to RSP with rsp_err=1, rsp_rdata=0, no memory access.
  - DMEM op with cmd_addr[2:0]!=0: same as above.
- WRITE (1 cycle):
  - Drive addr and wdata; imem gets cmd_wdata[31:0].
  - wen_ext or wen_ext_2 is high for exactly one cycle.
  - Then RSP with rsp_err=0, rsp_rdata=0.
- RD_REQ (1 cycle):
  - Drive addr with ren_ext or ren_ext_2 high for one cycle.
  - RD_WAIT counts RD_LAT cycles. rdata is sampled RD_LAT cycles after the ren cycle.
  - Imem data is zero-extended to 64 bits.
  - Then RSP with rsp_err=0.
  - addr holds its value through RD_WAIT; ren is 0 in RD_WAIT.
- RUN:
  - Count 0: go directly to RSP with rsp_rdata=0, enable never asserted.
  - Otherwise enable=1 for exactly count consecutive cycles, then enable=0 and RSP with rsp_rdata=count.
  - Counter is CNT_W bits and does not wrap: it stops at count.
  - run_abort=1 sampled in RUN: enable=0 on the next edge and rsp_rdata=cycles enable was high, which is strictly less than count.
  - run_abort outside RUN is ignored.
  - All wen/ren are 0 while enable=1, so the memories are never accessed externally while the CPU runs.
- RSP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On handshake, return to IDLE; cmd_ready=1 on the following cycle.
- Back-to-back throughput: write is 3 cycles command-to-command (IDLE, WRITE, RSP) with rsp_ready tied high.
- A command presented while not ready is not consumed; the host must hold it.

Test Plan:
- Reset, then WR_IMEM addr=0x8 wdata=0x00500093 -> wen_ext=1 for exactly one cycle with addr_ext=0x8 and wdata_ext=0x00500093; response rsp_err=0, rsp_rdata=0.
- WR_DMEM addr=0x10 wdata=0xDEADBEEF_CAFEF00D, then RD_DMEM addr=0x10 (memory model RD_LAT=1) -> ren_ext_2 pulses once; rsp_rdata=0xDEADBEEFCAFEF00D.
- RD_IMEM on a word containing 0xFFFFFFFF -> rsp_rdata=0x00000000FFFFFFFF.
- Unaligned and illegal commands:
  - RD_DMEM addr=0x14 -> rsp_err=1, no ren_ext_2 pulse.
  - WR_IMEM addr=0x2 -> rsp_err=1, no wen_ext pulse.
  - op=6 -> rsp_err=1.
- RUN count=5 -> enable high exactly 5 cycles, rsp_rdata=5.
  - RUN count=0 -> enable never high, rsp_rdata=0.
  - RUN count=100 with run_abort on the 10th enable cycle -> rsp_rdata=10.
- Hold rsp_ready=0 for 7 cycles -> rsp_valid and rsp_rdata are stable and cmd_ready=0 throughout.
  - Assert rst during RUN -> enable=0 after that edge, no response, cmd_ready=1 after rst is released.
